// File: rtl/lcd_spi_scheduler_if.sv
// Signal bundle between the LCD scheduler, the sprite frame buffer and spi_master.
// The scheduler takes the master view; the frame buffer / spi_master side takes the slave view.
interface lcd_spi_scheduler_if;
  logic       avail;
  logic       frame_req;
  logic [7:0] fb_data;
  logic [7:0] message;
  logic       spistart;
  logic       comm;
  logic [8:0] fb_addr;
  logic       fb_rd;
  logic       ready;
  logic       busy;
  logic       frame_done;

  modport master (
    input  avail, frame_req, fb_data,
    output message, spistart, comm, fb_addr, fb_rd, ready, busy, frame_done
  );

  modport slave (
    output avail, frame_req, fb_data,
    input  message, spistart, comm, fb_addr, fb_rd, ready, busy, frame_done
  );
endinterface

// File: rtl/lcd_spi_scheduler.sv
// Sequences spi_master for the PCD8544 84x48 LCD: power-up delay, init command list,
// then on each refresh request the address-set commands followed by a full frame of display bytes.
module lcd_spi_scheduler #(
  parameter int FRAME_BYTES    = 504,
  parameter int POWERUP_CYCLES = 50000,
  parameter int INIT_LEN       = 6
) (
  input  logic                clock_i,
  input  logic                reset_i,
  lcd_spi_scheduler_if.master bus_io
);

  localparam int CNT_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int IDX_W = $clog2(INIT_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INIT_LEN - 1);
  localparam logic [8:0]       ADDR_LAST = 9'(FRAME_BYTES - 1);

  localparam logic [3:0] S_POWERUP    = 4'd0;
  localparam logic [3:0] S_INIT_ISSUE = 4'd1;
  localparam logic [3:0] S_INIT_WAIT  = 4'd2;
  localparam logic [3:0] S_IDLE       = 4'd3;
  localparam logic [3:0] S_ADDR_ISSUE = 4'd4;
  localparam logic [3:0] S_ADDR_WAIT  = 4'd5;
  localparam logic [3:0] S_FETCH      = 4'd6;
  localparam logic [3:0] S_LATCH      = 4'd7;
  localparam logic [3:0] S_DATA_ISSUE = 4'd8;
  localparam logic [3:0] S_DATA_WAIT  = 4'd9;

  // extended instruction set, Vop, temp coeff, bias, basic set, normal display
  function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] i);
    logic [7:0] c;
    case (i)
      IDX_W'(0): c = 8'h21;
      IDX_W'(1): c = 8'hB1;
      IDX_W'(2): c = 8'h04;
      IDX_W'(3): c = 8'h14;
      IDX_W'(4): c = 8'h20;
      IDX_W'(5): c = 8'h0C;
      default:   c = 8'h00;
    endcase
    return c;
  endfunction

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             addr_sel_q, addr_sel_d;
  logic             ack_q, ack_d;
  logic             pending_q, pending_d;
  logic [7:0]       message_q, message_d;
  logic             comm_q, comm_d;
  logic             spistart_q, spistart_d;
  logic [8:0]       fb_addr_q, fb_addr_d;
  logic             ready_q, ready_d;
  logic             frame_done_q, frame_done_d;
  logic             byte_done;

  // A byte is finished only once avail has dropped (ack) and then risen again.
  assign byte_done = ack_q && bus_io.avail;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    addr_sel_d   = addr_sel_q;
    ack_d        = ack_q;
    pending_d    = pending_q;
    message_d    = message_q;
    comm_d       = comm_q;
    spistart_d   = 1'b0;
    fb_addr_d    = fb_addr_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;

    if (state_q != S_IDLE && bus_io.frame_req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_POWERUP: begin
        if (cnt_q == CNT_LAST) begin
          idx_d   = '0;
          state_d = S_INIT_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_INIT_ISSUE: begin
        if (bus_io.avail) begin
          message_d  = init_cmd(idx_q);
          comm_d     = 1'b1;
          spistart_d = 1'b1;
          ack_d      = 1'b0;
          state_d    = S_INIT_WAIT;
        end
      end

      S_INIT_WAIT: begin
        if (!bus_io.avail) begin
          ack_d = 1'b1;
        end
        if (byte_done) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_INIT_ISSUE;
          end
        end
      end

      S_IDLE: begin
        if (bus_io.frame_req || pending_q) begin
          pending_d  = 1'b0;
          addr_sel_d = 1'b0;
          fb_addr_d  = '0;
          state_d    = S_ADDR_ISSUE;
        end
      end

      S_ADDR_ISSUE: begin
        if (bus_io.avail) begin
          message_d  = addr_sel_q ? 8'h80 : 8'h40;
          comm_d     = 1'b1;
          spistart_d = 1'b1;
          ack_d      = 1'b0;
          state_d    = S_ADDR_WAIT;
        end
      end

      S_ADDR_WAIT: begin
        if (!bus_io.avail) begin
          ack_d = 1'b1;
        end
        if (byte_done) begin
          if (addr_sel_q) begin
            fb_addr_d = '0;
            state_d   = S_FETCH;
          end else begin
            addr_sel_d = 1'b1;
            state_d    = S_ADDR_ISSUE;
          end
        end
      end

      // fb_rd is high for this single cycle; the buffer answers in LATCH.
      S_FETCH: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        message_d = bus_io.fb_data;
        comm_d    = 1'b0;
        state_d   = S_DATA_ISSUE;
      end

      S_DATA_ISSUE: begin
        if (bus_io.avail) begin
          spistart_d = 1'b1;
          ack_d      = 1'b0;
          state_d    = S_DATA_WAIT;
        end
      end

      S_DATA_WAIT: begin
        if (!bus_io.avail) begin
          ack_d = 1'b1;
        end
        if (byte_done) begin
          if (fb_addr_q == ADDR_LAST) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            fb_addr_d = fb_addr_q + 9'd1;
            state_d   = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_POWERUP;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_POWERUP;
      cnt_q        <= '0;
      idx_q        <= '0;
      addr_sel_q   <= 1'b0;
      ack_q        <= 1'b0;
      pending_q    <= 1'b0;
      message_q    <= 8'h00;
      comm_q       <= 1'b1;
      spistart_q   <= 1'b0;
      fb_addr_q    <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      addr_sel_q   <= addr_sel_d;
      ack_q        <= ack_d;
      pending_q    <= pending_d;
      message_q    <= message_d;
      comm_q       <= comm_d;
      spistart_q   <= spistart_d;
      fb_addr_q    <= fb_addr_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus_io.message    = message_q;
  assign bus_io.spistart   = spistart_q;
  assign bus_io.comm       = comm_q;
  assign bus_io.fb_addr    = fb_addr_q;
  assign bus_io.fb_rd      = (state_q == S_FETCH);
  assign bus_io.ready      = ready_q;
  assign bus_io.busy       = (state_q != S_IDLE);
  assign bus_io.frame_done = frame_done_q;

  a_addr_range: assert property (@(posedge clock_i) disable iff (reset_i)
    fb_addr_q <= ADDR_LAST);
  a_single_start: assert property (@(posedge clock_i) disable iff (reset_i)
    spistart_q |=> !spistart_q);

endmodule

// File: doc/lcd_spi_scheduler.md
Name: lcd_spi_scheduler

Overview:
- Sequences the shared spi_master for the 84x48 PCD8544 LCD.
- After reset it waits a power-up delay, then issues the fixed init command list.
- Each frame refresh request issues the address-set commands, then streams FRAME_BYTES display bytes read from the sprite frame buffer.
- Sits between the frame buffer/sprite logic and spi_master; drives message, spistart and comm, and consumes avail.

Parameters:
- FRAME_BYTES, 504, data bytes per refresh (84 columns x 6 banks).
- POWERUP_CYCLES, 50000, clock cycles held in power-up wait after reset (1 ms at 50 MHz).
- INIT_LEN, 6, number of init commands.

Ports:
- clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- avail  in  1  spi_master idle flag (1 = ready for a byte)
- frame_req  in  1  one-cycle pulse requesting a full refresh
- fb_data  in  8  frame buffer read data, valid 1 cycle after fb_rd
- message  out  8  byte to spi_master data_in
- spistart  out  1  one-cycle start pulse to spi_master
- comm  out  1  1 = command byte (DC low at LCD), 0 = display data
- fb_addr  out  9  frame buffer byte address, 0..FRAME_BYTES-1
- fb_rd  out  1  frame buffer read strobe
- ready  out  1  high once init is complete
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last data byte completes

Behaviour:
- Reset values:
  - message=0, spistart=0, comm=1, fb_addr=0, fb_rd=0, ready=0, busy=1, frame_done=0.
  - Pending flag cleared; state=POWERUP; delay counter=0.
  - Reset mid-transfer aborts immediately, with no further spistart.
- Init table, in order, all with comm=1: 0x21, 0xB1, 0x04, 0x14, 0x20, 0x0C.
- Address commands before every frame, both with comm=1: 0x40, then 0x80.
- Byte handshake (ISSUE/WAIT pair):
  - ISSUE: when avail=1, drive message/comm and pulse spistart for exactly 1 cycle, then go to WAIT. If avail=0, stay in ISSUE.
  - message and comm stay stable from the spistart cycle until the WAIT state exits.
  - WAIT: first wait for avail=0 (acknowledge), then for avail=1 (byte done). An avail=1 seen before the drop is ignored.
  - At most one spistart per byte.
- States:
  - POWERUP: count to POWERUP_CYCLES-1, then go to INIT_ISSUE with idx=0.
  - INIT_ISSUE/INIT_WAIT: send table[idx]. After WAIT completes, idx++. When idx==INIT_LEN, set ready=1 and go to IDLE.
  - IDLE: busy=0. On frame_req or pending=1, clear pending and go to ADDR_ISSUE with a=0.
  - ADDR_ISSUE/ADDR_WAIT: send 0x40, then 0x80, then go to FETCH with fb_addr=0.
  - FETCH: assert fb_rd for 1 cycle, go to LATCH.
  - LATCH: capture fb_data into message with comm=0, go to DATA_ISSUE.
  - DATA_ISSUE/DATA_WAIT: send the byte. After completion:
    - if fb_addr==FRAME_BYTES-1: pulse frame_done, go to IDLE.
    - else: fb_addr++, go to FETCH.
- frame_req arriving in any non-IDLE state (including POWERUP/INIT) sets pending.
  - Pending is one deep; extra requests merge.
  - A request in the same cycle frame_done pulses is kept as pending, and a new frame starts on the next IDLE cycle.
- fb_addr never exceeds FRAME_BYTES-1 and wraps to 0 only at frame start.
- busy=1 in all states except IDLE. ready stays 1 until Reset.

Test Plan:
- Release Reset with avail tied high via a behavioural spi_master model (avail low 16 cycles after each spistart) -> no spistart for 50000 cycles. Then exactly 6 spistart pulses carrying 0x21,0xB1,0x04,0x14,0x20,0x0C with comm=1, then ready=1 and busy=0.
- After init, pulse frame_req with a frame buffer holding data=addr[7:0] -> sequence 0x40,0x80 (comm=1) followed by 504 data bytes 0x00..0xFF,0x00..0xF7 (comm=0). frame_done pulses once, 1 cycle after the last byte's avail rises.
- Pulse frame_req 3 times during a refresh and once during init -> exactly one extra frame follows each; no lost or duplicated bytes; spistart count = 6 + 2x506.
- Model holds avail=0 for 200 cycles before one byte -> spistart stays low and message/comm stay stable throughout; transfer resumes correctly when avail rises.
- Assert Reset during data byte 100 -> on the next cycle spistart=0, ready=0, busy=1. POWERUP restarts, and the full init sequence is resent.
- Model pulses avail=1 without the preceding drop, a glitch during WAIT -> no premature advance; the next byte is issued only after a genuine 1->0->1 sequence.
